mem_stage_pipe: RTL and testbench

//  Parametrised MIPS MEMORY stage with valid/ready pipeline handshake on both sides.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/dmem_ram.sv | 33 +++
 rtl/mem_stage_pipe.sv | 154 +++++++++++++++
 tb/tb_mem_stage_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM stage: access sizes, stage states,
// byte-lane enables and load extension on a 32-bit word.
package mem_pkg;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StFull = 2'd2;

  localparam int unsigned WordW = 32;

  // Size encoding 3 behaves as a word access.
  function automatic logic [3:0] lane_en(logic [1:0] size, logic [1:0] off);
    case (size)
      SzByte:  lane_en = 4'b0001 << off;
      SzHalf:  lane_en = off[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [WordW-1:0] load_ext(logic [WordW-1:0] word, logic [1:0] size,
                                                logic [1:0] off, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SzByte:  load_ext = {{24{b[7] & ~uns}}, b};
      SzHalf:  load_ext = {{16{h[15] & ~uns}}, h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Data RAM for the MEM stage: DEPTH words, per-byte write enable, registered
// read that only updates when a read is requested.
module dmem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [DATA_W/8-1:0]      be_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  localparam int unsigned NumBytes = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    // Holding the read register keeps load data stable while WB stalls.
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage_pipe.sv
// MIPS MEM stage with valid/ready on both sides, data RAM, MEM/WB register and
// branch resolution. Define MEM_ALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_branch,
  input  logic              in_zero,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [WB_W-1:0]   in_wb_ctl,
  input  logic [REG_W-1:0]  in_wreg,
  output logic              pcsrc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_wb_ctl,
  output logic [DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_wreg,
  output logic              out_trap
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned NumBytes = DATA_W / 8;
  localparam logic [2:0]  LatInit  = 3'(RD_LAT - 1);

  logic [1:0]          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                accept, misalign, do_load, do_store;
  logic [1:0]          size_n, off;
  logic [NumBytes-1:0] be;
  logic [DATA_W-1:0]   wdata_rep, ram_rdata;

  logic [WB_W-1:0]     wb_q;
  logic [REG_W-1:0]    wreg_q;
  logic [DATA_W-1:0]   alu_q;
  logic                ld_q, ld_uns_q;
  logic [1:0]          ld_size_q, ld_off_q;

  assign size_n = (in_size == SzByte || in_size == SzHalf) ? in_size : SzWord;

`ifdef MEM_ALIGN_TRAP_EN
  logic trap_q;
  assign misalign = ((size_n == SzHalf) && in_addr[0]) ||
                    ((size_n == SzWord) && (in_addr[1:0] != 2'b00));
  assign off      = in_addr[1:0];
  assign out_trap = trap_q;
`else
  assign misalign = 1'b0;
  assign off      = (size_n == SzWord) ? 2'b00 :
                    (size_n == SzHalf) ? {in_addr[1], 1'b0} : in_addr[1:0];
  assign out_trap = 1'b0;
`endif

  // Gating with rst_n keeps the RAM untouched and pcsrc low while reset is held.
  assign in_ready = rst_n & ((state_q == StIdle) | ((state_q == StFull) & out_ready));
  assign accept   = in_valid & in_ready;
  assign pcsrc    = accept & in_branch & in_zero;
  assign do_store = accept & in_mem_write & ~misalign;
  assign do_load  = accept & in_mem_read & ~in_mem_write & ~misalign;

  assign be        = NumBytes'(lane_en(size_n, off));
  assign wdata_rep = (size_n == SzByte) ? {NumBytes{in_wdata[7:0]}} :
                     (size_n == SzHalf) ? {(NumBytes/2){in_wdata[15:0]}} : in_wdata;

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (do_store),
    .be_i    (be),
    .re_i    (do_load),
    .addr_i  (in_addr[AW+1:2]),
    .wdata_i (wdata_rep),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (do_load && RD_LAT > 1) begin
        state_d = StWait;
        cnt_d   = LatInit;
      end else begin
        state_d = StFull;
      end
    end else begin
      case (state_q)
        StWait: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StFull;
        end
        StFull:  if (out_ready) state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      wb_q      <= '0;
      wreg_q    <= '0;
      alu_q     <= '0;
      ld_q      <= 1'b0;
      ld_uns_q  <= 1'b0;
      ld_size_q <= 2'b00;
      ld_off_q  <= 2'b00;
`ifdef MEM_ALIGN_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wb_q      <= in_wb_ctl;
        wreg_q    <= in_wreg;
        alu_q     <= DATA_W'(in_addr);
        ld_q      <= do_load;
        ld_uns_q  <= in_unsigned;
        ld_size_q <= size_n;
        ld_off_q  <= off;
`ifdef MEM_ALIGN_TRAP_EN
        trap_q    <= misalign;
`endif
      end
    end
  end

  assign out_valid      = (state_q == StFull);
  assign out_wb_ctl     = wb_q;
  assign out_wreg       = wreg_q;
  assign out_alu_result = alu_q;
  assign out_rdata      = ld_q ? DATA_W'(load_ext(WordW'(ram_rdata), ld_size_q, ld_off_q,
                                                  ld_uns_q)) : '0;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe (RD_LAT=3): byte-array memory model,
// directed corner cases followed by randomized traffic with random back-pressure.
module tb_mem_stage_pipe;

  localparam int unsigned RdLat    = 3;
  localparam int unsigned MemBytes = 1024;
`ifdef MEM_ALIGN_TRAP_EN
  localparam logic [31:0] W20Exp  = 32'h1122_3344;
  localparam logic        TrapExp = 1'b1;
`else
  localparam logic [31:0] W20Exp  = 32'h1122_ABCD;
  localparam logic        TrapExp = 1'b0;
`endif

  typedef struct {
    logic        br, zero, rd, wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic [1:0]  wb;
    logic [4:0]  wreg;
  } op_t;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rdata, alu;
    logic [4:0]  wreg;
    logic        trap;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_branch = 1'b0, in_zero = 1'b0;
  logic        in_mem_read = 1'b0, in_mem_write = 1'b0, in_unsigned = 1'b0;
  logic [1:0]  in_size = 2'd0, in_wb_ctl = 2'd0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [4:0]  in_wreg = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, pcsrc, out_valid, out_trap;
  logic [1:0]  out_wb_ctl;
  logic [31:0] out_rdata, out_alu_result;
  logic [4:0]  out_wreg;

  exp_t        sb_q[$];
  logic [7:0]  mem_m [MemBytes];
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] last_rdata = '0;
  logic        last_trap = 1'b0;
  logic        rdy_rand = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_pipe #(
    .DATA_W (32), .ADDR_W (32), .DEPTH (256), .REG_W (5), .WB_W (2), .RD_LAT (RdLat)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_branch      (in_branch),
    .in_zero        (in_zero),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_size        (in_size),
    .in_unsigned    (in_unsigned),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_wb_ctl      (in_wb_ctl),
    .in_wreg        (in_wreg),
    .pcsrc          (pcsrc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_wb_ctl     (out_wb_ctl),
    .out_rdata      (out_rdata),
    .out_alu_result (out_alu_result),
    .out_wreg       (out_wreg),
    .out_trap       (out_trap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic rd, input logic wr, input logic uns,
                             input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wdata);
    op_t o;
    o.br = 1'b0; o.zero = 1'b0; o.rd = rd; o.wr = wr; o.uns = uns; o.sz = sz;
    o.addr = addr; o.wdata = wdata; o.wb = 2'($urandom); o.wreg = 5'($urandom);
    return o;
  endfunction

  // Reference behaviour: little-endian byte memory, address taken modulo its size.
  task automatic model_op(input op_t o, output exp_t e);
    int unsigned nb, b;
    logic [31:0] v;
    logic        mis;
    nb = (o.sz == 2'd0) ? 1 : (o.sz == 2'd1) ? 2 : 4;
`ifdef MEM_ALIGN_TRAP_EN
    mis = (o.addr % nb) != 0;
`else
    mis = 1'b0;
`endif
    b = o.addr % MemBytes;
    b = b - (b % nb);
    e.wb = o.wb; e.wreg = o.wreg; e.alu = o.addr; e.trap = mis; e.rdata = '0;
    if (!mis) begin
      if (o.wr) begin
        for (int i = 0; i < nb; i++) mem_m[b+i] = o.wdata[8*i +: 8];
      end else if (o.rd) begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_m[b+i]) << (8*i));
        if (!o.uns && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
        e.rdata = v;
      end
    end
  endtask

  task automatic apply(input op_t o);
    in_branch = o.br; in_zero = o.zero; in_mem_read = o.rd; in_mem_write = o.wr;
    in_unsigned = o.uns; in_size = o.sz; in_addr = o.addr; in_wdata = o.wdata;
    in_wb_ctl = o.wb; in_wreg = o.wreg;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input op_t o);
    int  n;
    bit  done;
    exp_t e;
    n = 0; done = 0;
    apply(o);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_op(o, e);
        sb_q.push_back(e);
        check("pcsrc_accept", {31'd0, pcsrc}, {31'd0, o.br & o.zero});
        done = 1;
      end else begin
        check("pcsrc_stalled", {31'd0, pcsrc}, 32'd0);
        n++;
        if (n > 50) begin
          checks++; errors++;
          $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: pops on each handshake, and checks outputs stay frozen under back-pressure.
  initial begin
    exp_t        e;
    logic        held;
    logic [1:0]  s_wb;
    logic [31:0] s_rd, s_alu;
    logic [4:0]  s_wreg;
    logic        s_trap;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", {31'd0, out_valid}, 32'd1);
          check("hold_rdata", out_rdata, s_rd);
          check("hold_alu", out_alu_result, s_alu);
          check("hold_meta", {24'd0, s_trap, out_wreg, out_wb_ctl},
                {24'd0, s_trap, s_wreg, s_wb});
          check("hold_trap", {31'd0, out_trap}, {31'd0, s_trap});
        end
        held = 1'b0;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got alu=%h with empty scoreboard, required none",
                     out_alu_result);
          end else begin
            e = sb_q.pop_front();
            check("out_wb_ctl", {30'd0, out_wb_ctl}, {30'd0, e.wb});
            check("out_rdata", out_rdata, e.rdata);
            check("out_alu_result", out_alu_result, e.alu);
            check("out_wreg", {27'd0, out_wreg}, {27'd0, e.wreg});
            check("out_trap", {31'd0, out_trap}, {31'd0, e.trap});
            last_rdata = out_rdata;
            last_trap  = out_trap;
          end
        end else if (out_valid) begin
          held = 1'b1;
          s_wb = out_wb_ctl; s_rd = out_rdata; s_alu = out_alu_result;
          s_wreg = out_wreg; s_trap = out_trap;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    int  t0;
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_rdata", out_rdata, 32'd0);
    check("rst_out_alu", out_alu_result, 32'd0);
    check("rst_out_meta", {24'd0, out_trap, out_wreg, out_wb_ctl}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_pcsrc", {31'd0, pcsrc}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Word store, then signed and unsigned byte loads from the top byte.
    send(mk(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'hDEAD_BEEF));
    send(mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h13, 32'h0));
    drain();
    check("t2_signed_byte", last_rdata, 32'hFFFF_FFDE);
    send(mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h13, 32'h0));
    drain();
    check("t2_unsigned_byte", last_rdata, 32'h0000_00DE);

    // Load latency, then ALU throughput.
    send(mk(1'b1, 1'b0, 1'b1, 2'd1, 32'h12, 32'h0));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t3_in_ready", {31'd0, in_ready}, {31'd0, (c == 3)});
      check("t3_out_valid", {31'd0, out_valid}, {31'd0, (c == 3)});
      @(posedge clk); #1;
    end
    t0 = cyc;
    for (int k = 0; k < 4; k++) send(mk(1'b0, 1'b0, 1'b0, 2'd2, 32'h100 + k, 32'h0));
    check("t3_throughput", 32'(cyc - t0), 32'd4);

    // Back-pressure with a pending branch op.
    out_ready = 1'b0;
    o = mk(1'b0, 1'b0, 1'b0, 2'd2, 32'h200, 32'h0);
    o.br = 1'b1; o.zero = 1'b1;
    apply(o);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_in_ready", {31'd0, in_ready}, 32'd0);
      check("t4_pcsrc", {31'd0, pcsrc}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(o);
    drain();

    // Branch resolution.
    apply(o);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_pcsrc_novalid", {31'd0, pcsrc}, 32'd0);
    @(posedge clk); #1;
    send(o);
    o.zero = 1'b0;
    send(o);
    drain();

    // Misaligned half store.
    send(mk(1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h1122_3344));
    send(mk(1'b0, 1'b1, 1'b0, 2'd1, 32'h21, 32'h0000_ABCD));
    drain();
    check("t6_trap", {31'd0, last_trap}, {31'd0, TrapExp});
    send(mk(1'b1, 1'b0, 1'b0, 2'd2, 32'h20, 32'h0));
    drain();
    check("t6_word", last_rdata, W20Exp);

    // Reset mid-WAIT with a store presented during reset.
    send(mk(1'b1, 1'b0, 1'b0, 2'd2, 32'h20, 32'h0));
    #2 rst_n = 1'b0;
    apply(mk(1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'hFFFF_FFFF));
    in_valid = 1'b1;
    #1;
    check("t1_out_valid", {31'd0, out_valid}, 32'd0);
    check("t1_out_rdata", out_rdata, 32'd0);
    check("t1_out_alu", out_alu_result, 32'd0);
    check("t1_out_meta", {24'd0, out_trap, out_wreg, out_wb_ctl}, 32'd0);
    check("t1_pcsrc", {31'd0, pcsrc}, 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2 in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    check("t1_out_valid_after", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    send(mk(1'b1, 1'b0, 1'b0, 2'd2, 32'h20, 32'h0));
    drain();
    check("t1_ram_kept", last_rdata, W20Exp);

    // Randomized traffic over a 64-byte window with aliased upper address bits.
    rdy_rand = 1'b1;
    for (int w = 0; w < 16; w++) send(mk(1'b0, 1'b1, 1'b0, 2'd2, 32'(4 * w), $urandom));
    for (int k = 0; k < 400; k++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      o = mk(kind inside {[3:6], 9}, kind inside {[7:9]}, 1'($urandom), 2'($urandom),
             ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)), $urandom);
      o.br = 1'($urandom); o.zero = 1'($urandom);
      send(o);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
